// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and default parameters for the capture/drain controller.
package cdc_pkg;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_DEPTH        = 512;
    localparam int DEF_DIV_BITS     = 7;
    localparam int DEF_DRAIN_BITS   = 14;
    localparam int DEF_TEST_PATTERN = 1;

    typedef enum logic {
        MODE_ONESHOT = 1'b0,
        MODE_CONT    = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        DS_IDLE     = 2'd0,
        DS_SEND     = 2'd1,
        DS_WAIT_LOW = 2'd2
    } drain_state_t;
endpackage

// File: rtl/capture_fifo.sv
// capture_fifo: circular show-ahead buffer with extra-MSB pointers for full/empty.
module capture_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/capture_drain_ctrl.sv
// capture_drain_ctrl: strobed/manual capture into a buffer, drained word-by-word to an SPI master.
module capture_drain_ctrl
    import cdc_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH        = DEF_DEPTH,
    parameter int DIV_BITS     = DEF_DIV_BITS,
    parameter int DRAIN_BITS   = DEF_DRAIN_BITS,
    parameter int TEST_PATTERN = DEF_TEST_PATTERN
) (
    input  logic                     SYS_CLK,
    input  logic                     RST,
    input  logic                     MODE,
    input  logic                     ARM,
    input  logic [DATA_W-1:0]        SAMPLE_IN,
    input  logic                     MAN_WR,
    input  logic                     MAN_TX,
    input  logic                     TX_FIN,
    output logic                     TX_EN,
    output logic [DATA_W-1:0]        TX_DATA,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic [$clog2(DEPTH):0]   LEVEL,
    output logic                     CAPTURING,
    output logic [DATA_W-1:0]        SAMPLE_CNT,
    output logic [15:0]              OVF_CNT
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);

    logic [DIV_BITS-1:0]   div_cnt;
    logic [DRAIN_BITS-1:0] drain_cnt;
    logic                  drain_tick;
    logic [2:0]            wr_sync;
    logic [2:0]            tx_sync;
    logic                  fin_q;
    logic                  capturing;
    logic [DATA_W-1:0]     sample_cnt;
    logic [15:0]           ovf_cnt;
    drain_state_t          state;
    drain_state_t          next_state;
    logic                  strobe;
    logic                  wr_edge;
    logic                  tx_edge;
    logic                  fin_rise;
    logic                  is_cont;
    logic                  pop;
    logic                  wr_ok;
    logic                  push;
    logic                  drop;
    logic                  fills;

    assign strobe   = &div_cnt;
    assign wr_edge  = wr_sync[1] & ~wr_sync[2];
    assign tx_edge  = tx_sync[1] & ~tx_sync[2];
    assign fin_rise = TX_FIN & ~fin_q;
    assign is_cont  = mode_t'(MODE) == MODE_CONT;
    assign pop      = (state == DS_SEND) & fin_rise;
    assign wr_ok    = ~FULL | pop;
    assign push     = ((strobe & capturing) | wr_edge) & wr_ok;
    assign drop     = strobe & is_cont & ~wr_ok;
    assign fills    = push & ~pop & (LEVEL == LAST);

    assign TX_EN      = state == DS_SEND;
    assign CAPTURING  = capturing;
    assign SAMPLE_CNT = sample_cnt;
    assign OVF_CNT    = ovf_cnt;

    always_comb begin
        next_state = state == DS_IDLE     ? (((drain_tick | tx_edge) & ~EMPTY) ? DS_SEND : DS_IDLE) :
                     state == DS_SEND     ? (fin_rise ? DS_WAIT_LOW : DS_SEND) :
                     state == DS_WAIT_LOW ? (TX_FIN ? DS_WAIT_LOW : DS_IDLE) : DS_IDLE;
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            div_cnt    <= '0;
            drain_cnt  <= '0;
            drain_tick <= 1'b0;
            wr_sync    <= '0;
            tx_sync    <= '0;
            fin_q      <= 1'b0;
            capturing  <= 1'b1;
            sample_cnt <= '0;
            ovf_cnt    <= '0;
            state      <= DS_IDLE;
        end else begin
            div_cnt    <= div_cnt + DIV_BITS'(1);
            drain_cnt  <= drain_cnt + DRAIN_BITS'(1);
            drain_tick <= &drain_cnt;
            wr_sync    <= {wr_sync[1:0], MAN_WR};
            tx_sync    <= {tx_sync[1:0], MAN_TX};
            fin_q      <= TX_FIN;
            // One-shot freezes on the filling write; continuous never freezes.
            capturing  <= is_cont | (capturing & ~fills) | (ARM & ~FULL);
            if (push) sample_cnt <= sample_cnt + DATA_W'(1);
            if (drop && ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
            state      <= next_state;
        end
    end

    capture_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (SYS_CLK),
        .rst   (RST),
        .push  (push),
        .pop   (pop),
        .din   (TEST_PATTERN != 0 ? sample_cnt : SAMPLE_IN),
        .dout  (TX_DATA),
        .full  (FULL),
        .empty (EMPTY),
        .level (LEVEL)
    );
endmodule

// File: tb/tb_capture_drain_ctrl.sv
// tb_capture_drain_ctrl: directed table + sequence checks for capture_drain_ctrl (DEPTH=8, DIV_BITS=3).
module tb_capture_drain_ctrl;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mode = 1'b0;
    logic          arm = 1'b0;
    logic [DW-1:0] sample_in = '0;
    logic          man_wr = 1'b0;
    logic          man_tx = 1'b0;
    logic          tx_fin = 1'b0;
    logic          tx_en;
    logic [DW-1:0] tx_data;
    logic          full;
    logic          empty;
    logic [3:0]    level;
    logic          capturing;
    logic [DW-1:0] sample_cnt;
    logic [15:0]   ovf_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          adv;
        logic [3:0]  level;
        logic        full;
        logic        empty;
        logic        capt;
        logic [15:0] cnt;
    } fill_vec_t;

    fill_vec_t fv [8];

    capture_drain_ctrl #(
        .DATA_W       (DW),
        .DEPTH        (8),
        .DIV_BITS     (3),
        .DRAIN_BITS   (16),
        .TEST_PATTERN (1)
    ) dut (
        .SYS_CLK    (clk),
        .RST        (rst),
        .MODE       (mode),
        .ARM        (arm),
        .SAMPLE_IN  (sample_in),
        .MAN_WR     (man_wr),
        .MAN_TX     (man_tx),
        .TX_FIN     (tx_fin),
        .TX_EN      (tx_en),
        .TX_DATA    (tx_data),
        .FULL       (full),
        .EMPTY      (empty),
        .LEVEL      (level),
        .CAPTURING  (capturing),
        .SAMPLE_CNT (sample_cnt),
        .OVF_CNT    (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; the strobe is pending whenever cyc % 8 == 7.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        for (int i = 0; i < 8 && (cyc % 8) != 7; i++) @(negedge clk);
    endtask

    task automatic strobe_write();
        align();
        tick(1);
    endtask

    initial begin
        fv[0] = '{0,  4'd0, 1'b0, 1'b1, 1'b1, 16'd0};
        fv[1] = '{7,  4'd0, 1'b0, 1'b1, 1'b1, 16'd0};
        fv[2] = '{1,  4'd1, 1'b0, 1'b0, 1'b1, 16'd1};
        fv[3] = '{8,  4'd2, 1'b0, 1'b0, 1'b1, 16'd2};
        fv[4] = '{24, 4'd5, 1'b0, 1'b0, 1'b1, 16'd5};
        fv[5] = '{23, 4'd7, 1'b0, 1'b0, 1'b1, 16'd7};
        fv[6] = '{1,  4'd8, 1'b1, 1'b0, 1'b0, 16'd8};
        fv[7] = '{8,  4'd8, 1'b1, 1'b0, 1'b0, 16'd8};

        tick(3);
        rst = 1'b0;

        // One-shot fill: eight strobes to FULL, ninth writes nothing.
        for (int v = 0; v < 8; v++) begin
            tick(fv[v].adv);
            check($sformatf("fill%0d_level", v), level, fv[v].level);
            check($sformatf("fill%0d_full", v), full, fv[v].full);
            check($sformatf("fill%0d_empty", v), empty, fv[v].empty);
            check($sformatf("fill%0d_capt", v), capturing, fv[v].capt);
            check($sformatf("fill%0d_cnt", v), sample_cnt, fv[v].cnt);
            check($sformatf("fill%0d_ovf", v), ovf_cnt, 0);
            check($sformatf("fill%0d_txen", v), tx_en, 0);
        end

        arm = 1'b1;
        tick(1);
        arm = 1'b0;
        check("arm_full_capt", capturing, 0);

        // Drain three words via the manual request button.
        for (int i = 0; i < 3; i++) begin
            man_tx = 1'b1;
            tick(3);
            check($sformatf("drain%0d_txen", i), tx_en, 1);
            check($sformatf("drain%0d_data", i), tx_data, i);
            tick(2);
            check($sformatf("drain%0d_hold", i), tx_data, i);
            tx_fin = 1'b1;
            man_tx = 1'b0;
            tick(1);
            tx_fin = 1'b0;
            check($sformatf("drain%0d_txen_drop", i), tx_en, 0);
            check($sformatf("drain%0d_level", i), level, 7 - i);
            tick(3);
        end
        check("drain_head", tx_data, 3);
        check("drain_capt", capturing, 0);

        // Manual write: lands on the third edge, held level gives no repeat.
        man_wr = 1'b1;
        tick(2);
        check("manwr_early", level, 5);
        tick(1);
        check("manwr_level", level, 6);
        check("manwr_cnt", sample_cnt, 9);
        tick(10);
        check("manwr_hold_level", level, 6);
        check("manwr_hold_cnt", sample_cnt, 9);
        man_wr = 1'b0;
        tick(3);

        // Continuous mode: fill up, then five dropped strobes.
        mode = 1'b1;
        strobe_write();
        check("cont_level7", level, 7);
        check("cont_capt", capturing, 1);
        strobe_write();
        check("cont_full", full, 1);
        repeat (5) strobe_write();
        check("cont_ovf5", ovf_cnt, 5);
        check("cont_level8", level, 8);
        check("cont_cnt", sample_cnt, 11);

        // Strobe coinciding with a pop at FULL.
        man_tx = 1'b1;
        tick(3);
        check("cpop_txen", tx_en, 1);
        check("cpop_data", tx_data, 3);
        align();
        tx_fin = 1'b1;
        tick(1);
        tx_fin = 1'b0;
        man_tx = 1'b0;
        check("cpop_level", level, 8);
        check("cpop_full", full, 1);
        check("cpop_ovf", ovf_cnt, 5);
        check("cpop_cnt", sample_cnt, 12);
        check("cpop_txen", tx_en, 0);
        check("cpop_head", tx_data, 4);

        // Overflow counter saturation.
        force dut.ovf_cnt = 16'hFFFE;
        #1 release dut.ovf_cnt;
        strobe_write();
        check("ovf_ffff", ovf_cnt, 16'hFFFF);
        repeat (2) strobe_write();
        check("ovf_sat", ovf_cnt, 16'hFFFF);

        // Sample counter wrap on the next write.
        man_tx = 1'b1;
        tick(3);
        check("wrap_txen", tx_en, 1);
        tx_fin = 1'b1;
        tick(1);
        tx_fin = 1'b0;
        man_tx = 1'b0;
        check("wrap_pop_level", level, 7);
        force dut.sample_cnt = 16'hFFFF;
        #1 release dut.sample_cnt;
        strobe_write();
        check("wrap_cnt", sample_cnt, 0);
        check("wrap_level", level, 8);

        // Reset in SEND with a FIN edge in the same cycle.
        man_tx = 1'b1;
        tick(3);
        check("rst_send_txen", tx_en, 1);
        rst = 1'b1;
        tx_fin = 1'b1;
        man_tx = 1'b0;
        tick(1);
        check("rst_txen", tx_en, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_cnt", sample_cnt, 0);
        check("rst_full", full, 0);
        check("rst_capt", capturing, 1);
        check("rst_ovf", ovf_cnt, 0);
        rst = 1'b0;
        tx_fin = 1'b0;
        mode = 1'b0;

        // Drain request while EMPTY is discarded, not queued.
        man_tx = 1'b1;
        tick(3);
        check("mt_empty_txen3", tx_en, 0);
        tick(3);
        check("mt_empty_txen6", tx_en, 0);
        check("mt_empty_empty", empty, 1);
        tick(3);
        check("mt_later_level", level, 1);
        check("mt_later_txen", tx_en, 0);
        man_tx = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
